sync_fifo_ctl: RTL
==================

// Module: sync_fifo_ctl
// PURPOSE
//  Single-clock FIFO, parametrised successor of the dual-clock FIFO: same RESERVE/full/empty/has_data contract.
//  Adds selectable first-word-fall-through (FWFT) read mode, an occupancy count and programmable almost-full/empty flags.
//  Adds overflow/underflow error pulses.
//  Used inside one clock domain (packet buffers, rate smoothing) where CDC pointer sync is unnecessary.
// PARAMETERS
//  DATA_WIDTH     8    data word width
//  ADDR_WIDTH     12   log2 depth; DEPTH = 2**ADDR_WIDTH entries
//  RESERVE        0    full asserts when free space <= RESERVE (advisory headroom)
//  FWFT           0    0 = standard read (1-cycle latency), 1 = first-word-fall-through
//  AFULL_THRESH   DEPTH-4  almost_full when level >= AFULL_THRESH
//  AEMPTY_THRESH  4    almost_empty when level <= AEMPTY_THRESH
// PORTS
//  clk           in   1             single clock, all logic on posedge
//  rst           in   1             synchronous, active-high reset
//  wr_en         in   1             write request
//  wr_data       in   DATA_WIDTH    write data
//  full          out  1             free space <= RESERVE, or in reset
//  almost_full   out  1             level >= AFULL_THRESH
//  overflow      out  1             1-cycle pulse: wr_en while storage truly full
//  rd_en         in   1             read request (FWFT: pop/acknowledge)
//  rd_data       out  DATA_WIDTH    read data
//  empty         out  1             no readable word
//  has_data      out  1             ~empty; forced 0 in reset
//  almost_empty  out  1             level <= AEMPTY_THRESH
//  underflow     out  1             1-cycle pulse: rd_en while empty
//  level         out  ADDR_WIDTH+1  stored words, 0..DEPTH
// BEHAVIOUR
//  - Pointers are ADDR_WIDTH+1 bits; the MSB distinguishes full from empty; wrap modulo 2**(ADDR_WIDTH+1).
//  - All flags and level are registered; each updates on the edge after the causing write/read.
//  - Reset (edge with rst=1): pointers=0, level=0, empty=1, has_data=0, almost_empty=1, full=1, almost_full=0.
//  - Reset (cont.): overflow=underflow=0, rd_data=0. Contents are discarded.
//  - Reset (cont.): full drops on the first edge with rst=0. rst mid-operation aborts any in-flight read/prefetch.
//  - Write accepted iff wr_en && level != DEPTH. RESERVE does not block writes; full is advisory only.
//  - Write rejected at level==DEPTH: overflow pulses, no state changes.
//  - Read accepted iff rd_en && has_data. Read rejected while empty: underflow pulses, rd_data holds.
//  - Simultaneous accepted read+write: level unchanged; both pointers advance.
//  - Simultaneous rd_en+wr_en at level 0: write accepted, read rejected (underflow).
//  - Simultaneous rd_en+wr_en at level==DEPTH: read accepted, write rejected (overflow); full re-evaluates next edge.
//  - full = (DEPTH - level) <= RESERVE. RESERVE=0 gives full exactly at level==DEPTH.
//  - FWFT=0: empty = (level==0). Write at edge N -> empty=0 after N.
//  - FWFT=0: accepted read at edge N -> rd_data valid after N; rd_data holds between reads.
//  - FWFT=1: an output register is prefetched from RAM.
//  - FWFT=1: write into an empty FIFO at edge N -> rd_data valid and has_data=1 after edge N+2.
//  - FWFT=1: rd_en acknowledges the presented word; the next word is presented after the same edge if one is stored.
//  - FWFT=1: otherwise has_data=0 after that edge.
//  - FWFT=1: level counts the prefetched word; sustained 1 word/cycle throughput with rd_en held high.
//  - RAM: block style when ADDR_WIDTH > 6, else distributed. Storage is not reset.
// TESTING
//  - Reset then idle: full=1 during rst, 0 one edge later.
//  - Reset then idle: empty=1, level=0, no error pulses.
//  - FWFT=0, ADDR_WIDTH=2: write 1..4 -> level=4, full=1.
//  - FWFT=0, ADDR_WIDTH=2 (cont.): 5th write -> overflow pulse, level stays 4.
//  - FWFT=0, ADDR_WIDTH=2 (cont.): read 4 -> rd_data 1,2,3,4 each one edge after rd_en; then rd_en -> underflow pulse.
//  - FWFT=1: write 0xA5 at edge N -> rd_data=0xA5, has_data=1 after N+2.
//  - FWFT=1: continuous write+read of 1000 words -> in-order data, no gaps once primed.
//  - Wrap: 3*DEPTH mixed random read/write bursts -> data order matches model.
//  - Wrap (cont.): level matches model every cycle; simultaneous read+write keeps level.
//  - RESERVE=2, ADDR_WIDTH=3: full=1 at level 6; writes still accepted to level 8.
//  - RESERVE=2, ADDR_WIDTH=3 (cont.): almost_full/almost_empty toggle exactly at thresholds.
//  - Reset mid-burst at level 5 -> next cycle level=0, empty=1, prior data never emerges.

Source files
------------

// File: rtl/sync_fifo_ctl.sv
// rtl/sync_fifo_ctl.sv - single-clock FIFO controller with optional first-word-fall-through read port
module sync_fifo_ctl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 12,
  parameter int RESERVE       = 0,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  has_data,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   level
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef logic [ADDR_WIDTH:0] ptr_t;
  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t ONE_P   = ptr_t'(1);

  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  ptr_t                  wr_ptr_vis;
  ptr_t                  level_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ram_pop;
  logic                  has_data_next;
  logic [DATA_WIDTH-1:0] ram_q;

  assign wr_acc     = wr_en && (level != DEPTH_P);
  assign rd_acc     = rd_en && has_data;
  assign level_next = level + (wr_acc ? ONE_P : '0) - (rd_acc ? ONE_P : '0);

  // In FWFT mode a word becomes visible to the prefetch one edge after it is
  // written (wr_ptr_vis), giving a fixed two-edge fall-through latency while
  // still refilling the output register on the same edge it is acknowledged.
  always_comb begin
    ram_pop       = rd_acc;
    has_data_next = (level_next != '0);
    if (FWFT) begin
      ram_pop       = (!has_data || rd_acc) && (rd_ptr != wr_ptr_vis);
      has_data_next = ram_pop || (has_data && !rd_acc);
    end
  end

  if (ADDR_WIDTH > 6) begin : g_block_ram
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_acc && !rst) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
    assign ram_q = mem[rd_ptr[ADDR_WIDTH-1:0]];
  end else begin : g_dist_ram
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
      if (wr_acc && !rst) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
    assign ram_q = mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      wr_ptr_vis   <= '0;
      level        <= '0;
      has_data     <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_data      <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_P;
      if (ram_pop) begin
        rd_ptr  <= rd_ptr + ONE_P;
        rd_data <= ram_q;
      end
      wr_ptr_vis   <= wr_ptr;
      level        <= level_next;
      has_data     <= has_data_next;
      empty        <= !has_data_next;
      full         <= (DEPTH - int'(level_next)) <= RESERVE;
      almost_full  <= int'(level_next) >= AFULL_THRESH;
      almost_empty <= int'(level_next) <= AEMPTY_THRESH;
      overflow     <= wr_en && (level == DEPTH_P);
      underflow    <= rd_en && !has_data;
    end
  end
endmodule
